// File: rtl/reset_seq_mon.sv
// Receiving-end monitor for a power-enable / reset-line pair: synchronizes and
// debounces both lines, checks ordering and minimum power-on time, flags faults.
module reset_seq_mon #(
  parameter int unsigned RESETHL = 0,
  parameter int unsigned DEB     = 2,
  parameter int unsigned TP_MIN  = 1000,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pwr,
  input  logic        i_rst,
  input  logic        i_clr,
  output logic        o_ready,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic [31:0] o_tp_meas,
  output logic [1:0]  o_state
);

  localparam int unsigned DebW = (DEB > 1) ? $clog2(DEB) : 1;

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StPwrOn = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } state_e;

  localparam logic [1:0] CodeNone    = 2'd0;
  localparam logic [1:0] CodeNoPwr   = 2'd1;
  localparam logic [1:0] CodeEarly   = 2'd2;
  localparam logic [1:0] CodeTimeout = 2'd3;

  // Lane 0 is power, lane 1 is reset already mapped to "1 = released", so all
  // input flops can reset to 0 without a spurious release for either polarity.
  logic [1:0] line_raw;
  assign line_raw = {i_rst ^ (RESETHL != 0), i_pwr};

  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            filt_q, filt_d;
  logic [1:0][DebW-1:0]  deb_q, deb_d;

  always_comb begin
    filt_d = filt_q;
    deb_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_q[i] == DebW'(DEB - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          deb_d[i] = deb_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= line_raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      deb_q   <= deb_d;
    end
  end

  logic pwr, rel;
  assign pwr = filt_q[0];
  assign rel = filt_q[1];

  state_e      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tp_q, tp_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    if (state_q == StPwrOn && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      StOff: begin
        if (pwr && !rel) begin
          state_d = StPwrOn;
        end else if (!pwr && rel) begin
          state_d = StFault;
          code_d  = CodeNoPwr;
        end else if (pwr && rel) begin
          if (TP_MIN == 0) begin
            state_d = StRun;
            tp_d    = '0;
          end else begin
            state_d = StFault;
            code_d  = CodeEarly;
          end
        end
      end
      StPwrOn: begin
        if (!pwr) begin
          state_d = StOff;
        end else if (rel) begin
          // Release checks take precedence over a coincident timeout.
          if (cnt_q >= TP_MIN) begin
            state_d = StRun;
            tp_d    = cnt_q;
          end else begin
            state_d = StFault;
            code_d  = CodeEarly;
          end
        end else if (TIMEOUT != 0 && cnt_q == TIMEOUT) begin
          state_d = StFault;
          code_d  = CodeTimeout;
        end
      end
      StRun: begin
        if (!pwr && !rel) begin
          state_d = StOff;
        end else if (pwr && !rel) begin
          state_d = StPwrOn;
        end else if (!pwr && rel) begin
          state_d = StFault;
          code_d  = CodeNoPwr;
        end
      end
      StFault: begin
        if (i_clr) begin
          state_d = StOff;
          code_d  = CodeNone;
        end
      end
      default: state_d = StOff;
    endcase

    if (state_d == StPwrOn && state_q != StPwrOn) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      code_q  <= CodeNone;
      cnt_q   <= '0;
      tp_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tp_q    <= tp_d;
    end
  end

  assign o_state      = state_q;
  assign o_ready      = (state_q == StRun);
  assign o_fault      = (state_q == StFault);
  assign o_fault_code = code_q;
  assign o_tp_meas    = tp_q;

endmodule

// File: tb/tb_reset_seq_mon.sv
// Bench for reset_seq_mon: two instances (both reset polarities) checked every cycle
// against a sample-history model, plus directed literal expectations.
module tb_reset_seq_mon;

  localparam int unsigned DEB     = 2;
  localparam int unsigned TP_MIN  = 10;
  localparam int unsigned TIMEOUT = 50;

  logic clk, rst, pwr_pin, rst_pin, rst_pin_hl, clr;
  logic        ready [2];
  logic        fault [2];
  logic [1:0]  code  [2];
  logic [31:0] tp    [2];
  logic [1:0]  st    [2];

  int checks   = 0;
  int failures = 0;

  assign rst_pin_hl = ~rst_pin;

  reset_seq_mon #(.RESETHL(0), .DEB(DEB), .TP_MIN(TP_MIN), .TIMEOUT(TIMEOUT)) u_dut0 (
    .clk(clk), .rst(rst), .i_pwr(pwr_pin), .i_rst(rst_pin), .i_clr(clr),
    .o_ready(ready[0]), .o_fault(fault[0]), .o_fault_code(code[0]),
    .o_tp_meas(tp[0]), .o_state(st[0])
  );

  reset_seq_mon #(.RESETHL(1), .DEB(DEB), .TP_MIN(TP_MIN), .TIMEOUT(TIMEOUT)) u_dut1 (
    .clk(clk), .rst(rst), .i_pwr(pwr_pin), .i_rst(rst_pin_hl), .i_clr(clr),
    .o_ready(ready[1]), .o_fault(fault[1]), .o_fault_code(code[1]),
    .o_tp_meas(tp[1]), .o_state(st[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: per line, a history of raw pin samples (bit0 = newest); the filtered value
  // flips once the DEB samples that have passed the two sync stages all disagree with it.
  logic [15:0] sh_p [2];
  logic [15:0] sh_r [2];
  logic        mp [2];
  logic        mr [2];
  int          ms [2];
  logic [1:0]  mcode [2];
  logic [31:0] mcnt [2];
  logic [31:0] mtp [2];
  bit          model_on = 0;

  function automatic logic deb_next(logic [15:0] sh, logic f);
    for (int j = 1; j <= int'(DEB); j++) begin
      if (sh[j] == f) return f;
    end
    return ~f;
  endfunction

  task automatic fsm_step(int d, logic p, logic r, logic c);
    int ns;
    ns = ms[d];
    case (ms[d])
      0: begin
        if (p && !r) ns = 1;
        else if (!p && r) begin ns = 3; mcode[d] = 2'd1; end
        else if (p && r) begin
          if (TP_MIN == 0) begin ns = 2; mtp[d] = 0; end
          else begin ns = 3; mcode[d] = 2'd2; end
        end
      end
      1: begin
        if (!p) ns = 0;
        else if (r) begin
          if (mcnt[d] >= TP_MIN) begin ns = 2; mtp[d] = mcnt[d]; end
          else begin ns = 3; mcode[d] = 2'd2; end
        end else if (TIMEOUT != 0 && mcnt[d] == TIMEOUT) begin
          ns = 3; mcode[d] = 2'd3;
        end
      end
      2: begin
        if (!p && !r) ns = 0;
        else if (p && !r) ns = 1;
        else if (!p && r) begin ns = 3; mcode[d] = 2'd1; end
      end
      default: begin
        if (c) begin ns = 0; mcode[d] = 2'd0; end
      end
    endcase
    if (ns == 1 && ms[d] != 1) mcnt[d] = 0;
    else if (ms[d] == 1 && mcnt[d] != 32'hFFFF_FFFF) mcnt[d] = mcnt[d] + 1;
    ms[d] = ns;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          sh_p[d] = '0; sh_r[d] = '0; mp[d] = 0; mr[d] = 0;
          ms[d] = 0; mcode[d] = 0; mcnt[d] = 0; mtp[d] = 0;
        end else begin
          logic np, nr;
          np = deb_next(sh_p[d], mp[d]);
          nr = deb_next(sh_r[d], mr[d]);
          fsm_step(d, mp[d], mr[d], clr);
          sh_p[d] = {sh_p[d][14:0], pwr_pin};
          sh_r[d] = {sh_r[d][14:0], (d == 0) ? rst_pin : !rst_pin_hl};
          mp[d] = np;
          mr[d] = nr;
        end
      end
      if (rst) model_on = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        for (int d = 0; d < 2; d++) begin
          logic [37:0] act, exp;
          act = {st[d], ready[d], fault[d], code[d], tp[d]};
          exp = {ms[d][1:0], ms[d] == 2, ms[d] == 3, mcode[d], mtp[d]};
          checks++;
          if (act !== exp) begin
            failures++;
            $display("FAIL model_dut%0d t=%0t: got st=%0d rdy=%0d flt=%0d code=%0d tp=%0d want st=%0d rdy=%0d flt=%0d code=%0d tp=%0d",
                     d, $time, st[d], ready[d], fault[d], code[d], tp[d],
                     ms[d], ms[d] == 2, ms[d] == 3, mcode[d], mtp[d]);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scenario-relative cycle: rc=-1 means "at the negedge just before edge 0".
  int rc;
  task automatic begin_sc();
    rc = -1;
  endtask
  task automatic goto(int k);
    repeat (k - rc) @(posedge clk);
    @(negedge clk);
    rc = k;
  endtask

  initial begin
    rst = 1'b1; pwr_pin = 1'b0; rst_pin = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {30'd0, st[0]}, 32'd0);
    chk("reset_ready_fault", {30'd0, ready[0], fault[0]}, 32'd0);
    chk("reset_tp", tp[0], 32'd0);
    rst = 1'b0;

    // Legal sequence; the inverted-polarity instance must follow identically.
    begin_sc();
    pwr_pin = 1'b1;
    goto(3);  chk("legal_state_c3", {30'd0, st[0]}, 32'd0);
    goto(4);  chk("legal_state_c4", {30'd0, st[0]}, 32'd1);
    goto(19); rst_pin = 1'b1;
    goto(23); chk("legal_ready_c23", {31'd0, ready[0]}, 32'd0);
    goto(24); chk("legal_ready_c24", {31'd0, ready[0]}, 32'd1);
    chk("legal_tp", tp[0], 32'd19);
    chk("polarity_state", {30'd0, st[1]}, 32'd2);
    chk("polarity_tp", tp[1], 32'd19);

    // Re-reset from RUN, then a fresh release; clear pulse in RUN is ignored.
    goto(30);
    begin_sc();
    rst_pin = 1'b0;
    goto(3);  chk("rereset_c3", {30'd0, st[0]}, 32'd2);
    goto(4);  chk("rereset_state", {30'd0, st[0]}, 32'd1);
    chk("rereset_ready", {31'd0, ready[0]}, 32'd0);
    goto(14); rst_pin = 1'b1;
    goto(18); chk("rerun_c18", {30'd0, st[0]}, 32'd1);
    goto(19); chk("rerun_state", {30'd0, st[0]}, 32'd2);
    chk("rerun_tp", tp[0], 32'd14);
    goto(20); clr = 1'b1;
    goto(21); clr = 1'b0;
    chk("clr_in_run", {30'd0, st[0]}, 32'd2);

    // Orderly off: both lines drop together.
    goto(25);
    begin_sc();
    pwr_pin = 1'b0; rst_pin = 1'b0;
    goto(3);  chk("off_c3", {30'd0, st[0]}, 32'd2);
    goto(4);  chk("off_state", {30'd0, st[0]}, 32'd0);
    chk("off_fault", {31'd0, fault[0]}, 32'd0);
    chk("off_tp_held", tp[0], 32'd14);

    // Early release, sticky fault, then clear.
    goto(10);
    begin_sc();
    pwr_pin = 1'b1;
    goto(4);  rst_pin = 1'b1;
    goto(8);  chk("early_c8", {31'd0, fault[0]}, 32'd0);
    goto(9);  chk("early_fault", {31'd0, fault[0]}, 32'd1);
    chk("early_code", {30'd0, code[0]}, 32'd2);
    goto(10); pwr_pin = 1'b0; rst_pin = 1'b0;
    goto(16); chk("early_sticky", {30'd0, code[0]}, 32'd2);
    clr = 1'b1;
    goto(17); clr = 1'b0;
    chk("clr_state", {30'd0, st[0]}, 32'd0);
    chk("clr_code", {30'd0, code[0]}, 32'd0);
    chk("clr_tp_held", tp[0], 32'd14);

    // Timeout, then synchronous reset while in FAULT.
    goto(20);
    begin_sc();
    pwr_pin = 1'b1;
    goto(54); chk("to_c54", {31'd0, fault[0]}, 32'd0);
    goto(55); chk("to_fault", {31'd0, fault[0]}, 32'd1);
    chk("to_code", {30'd0, code[0]}, 32'd3);
    rst = 1'b1;
    goto(56); chk("rst_fault_state", {30'd0, st[0]}, 32'd0);
    chk("rst_fault_code", {30'd0, code[0]}, 32'd0);
    chk("rst_fault_tp", tp[0], 32'd0);
    rst = 1'b0; pwr_pin = 1'b0;

    // Reset released without power.
    goto(70);
    begin_sc();
    rst_pin = 1'b1;
    goto(3);  chk("nopwr_c3", {30'd0, st[0]}, 32'd0);
    goto(4);  chk("nopwr_code", {30'd0, code[0]}, 32'd1);
    chk("nopwr_hl_code", {30'd0, code[1]}, 32'd1);
    goto(5);  rst_pin = 1'b0;
    goto(10); clr = 1'b1;
    goto(11); clr = 1'b0;
    chk("nopwr_clr", {30'd0, st[0]}, 32'd0);

    // Release one cycle short of TP_MIN.
    goto(15);
    begin_sc();
    pwr_pin = 1'b1;
    goto(9);  rst_pin = 1'b1;
    goto(14); chk("tpmin_short_code", {30'd0, code[0]}, 32'd2);
    goto(15); pwr_pin = 1'b0; rst_pin = 1'b0;
    goto(21); clr = 1'b1;
    goto(22); clr = 1'b0;

    // One-cycle glitches on each line.
    goto(25);
    begin_sc();
    pwr_pin = 1'b1;
    goto(0);  pwr_pin = 1'b0;
    goto(10); chk("glitch_pwr", {30'd0, st[0]}, 32'd0);
    rst_pin = 1'b1;
    goto(11); rst_pin = 1'b0;
    goto(20); chk("glitch_rst", {30'd0, st[0]}, 32'd0);
    chk("glitch_rst_hl", {30'd0, st[1]}, 32'd0);

    // Release exactly at TP_MIN, then synchronous reset in RUN.
    begin_sc();
    pwr_pin = 1'b1;
    goto(10); rst_pin = 1'b1;
    goto(15); chk("tpmin_exact_state", {30'd0, st[0]}, 32'd2);
    chk("tpmin_exact_tp", tp[0], 32'd10);
    goto(18); rst = 1'b1;
    goto(19); chk("rst_run_ready", {31'd0, ready[0]}, 32'd0);
    chk("rst_run_state", {30'd0, st[1]}, 32'd0);
    chk("rst_run_tp", tp[0], 32'd0);
    chk("rst_run_tp_hl", tp[1], 32'd0);
    rst = 1'b0; pwr_pin = 1'b0; rst_pin = 1'b0;
    goto(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
